// File: rtl/pkt_capture_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pkt_capture_writer
// Description : Avalon-MM write master that stores captured Avalon-ST packet
//               words into a host buffer [pkt_begin, pkt_end) through a small
//               decoupling FIFO, reporting progress via a 2-bit state.
// Revision    : 1.0 - initial release
// ============================================================================
module pkt_capture_writer #(
    parameter int N          = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] control,
    input  logic [N-1:0] pkt_begin,
    input  logic [N-1:0] pkt_end,
    output logic [1:0]   state,
    input  logic [N-1:0] snk_data,
    input  logic         snk_valid,
    input  logic         snk_sop,
    input  logic         snk_eop,
    output logic         snk_ready,
    output logic [N-1:0] m_address,
    output logic         m_write,
    output logic [N-1:0] m_writedata,
    input  logic         m_waitrequest,
    output logic [N-1:0] wr_ptr,
    output logic [15:0]  pkt_count
);

    localparam int             c_AW         = $clog2(FIFO_DEPTH);
    localparam int             c_ENABLE_BIT = 2;
    localparam int             c_WRAP_BIT   = 3;
    localparam logic [N-1:0]   c_WORD_BYTES = N'(4);
    localparam logic [c_AW:0]  c_PTR_ONE    = (c_AW+1)'(1);
    localparam logic [15:0]    c_COUNT_MAX  = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_CAPTURE = 2'b01,
        S_DONE    = 2'b10,
        S_ERROR   = 2'b11
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            r_enable_q;
    logic [N-1:0]    r_begin;
    logic [N-1:0]    r_end;
    logic [N-1:0]    r_wr_ptr;
    logic [15:0]     r_pkt_count;
    logic            r_in_pkt;
    logic            r_stop;
    logic            r_m_write;
    logic            r_m_eop;
    logic [N-1:0]    r_m_writedata;
    logic [N:0]      r_mem [FIFO_DEPTH];
    logic [c_AW:0]   r_fifo_wptr;
    logic [c_AW:0]   r_fifo_rptr;

    logic            w_enable;
    logic            w_wrap;
    logic            w_enable_rise;
    logic            w_cfg_bad;
    logic            w_start;
    logic            w_capture;
    logic            w_fifo_empty;
    logic            w_fifo_full;
    logic            w_complete;
    logic [N-1:0]    w_ptr_inc;
    logic            w_at_end;
    logic            w_final;
    logic            w_drain_stop;
    logic            w_snk_ready;
    logic            w_accept;
    logic            w_push;
    logic            w_pop;
    logic            w_unused;

    assign w_enable      = control[c_ENABLE_BIT];
    assign w_wrap        = control[c_WRAP_BIT];
    assign w_unused      = ^{control[N-1:c_WRAP_BIT+1], control[c_ENABLE_BIT-1:0]};
    assign w_enable_rise = w_enable && !r_enable_q;
    assign w_cfg_bad     = (pkt_begin >= pkt_end) || (pkt_begin[1:0] != 2'b00)
                           || (pkt_end[1:0] != 2'b00);
    assign w_start       = (r_state == S_IDLE) && w_enable_rise && !w_cfg_bad;
    assign w_capture     = (r_state == S_CAPTURE);

    assign w_fifo_empty  = (r_fifo_wptr == r_fifo_rptr);
    assign w_fifo_full   = (r_fifo_wptr[c_AW] != r_fifo_rptr[c_AW])
                           && (r_fifo_wptr[c_AW-1:0] == r_fifo_rptr[c_AW-1:0]);

    // A completing write to the last buffer word without wrap ends capture.
    assign w_complete    = r_m_write && !m_waitrequest;
    assign w_ptr_inc     = r_wr_ptr + c_WORD_BYTES;
    assign w_at_end      = (w_ptr_inc == r_end);
    assign w_final       = w_complete && w_at_end && !w_wrap;

    // With enable low, new packets are refused; an open packet runs to eop.
    assign w_drain_stop  = !w_enable && !r_in_pkt;
    assign w_snk_ready   = w_capture && !w_fifo_full && !r_stop && !w_drain_stop && !w_final;
    assign w_accept      = snk_valid && w_snk_ready;
    assign w_push        = w_accept && (snk_sop || r_in_pkt);
    assign w_pop         = w_capture && !w_fifo_empty && (!r_m_write || w_complete) && !w_final;

    // Next-state decode for the capture controller.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_enable_rise) begin
                    w_state_next = w_cfg_bad ? S_ERROR : S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (w_final) begin
                    w_state_next = S_DONE;
                end else if (w_drain_stop && w_fifo_empty && !r_m_write) begin
                    w_state_next = S_IDLE;
                end
            end
            S_DONE, S_ERROR: begin
                if (!w_enable) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register and enable edge history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_enable_q <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_enable_q <= w_enable;
        end
    end

    // Buffer window capture, write pointer and completed-packet counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_begin     <= '0;
            r_end       <= '0;
            r_wr_ptr    <= '0;
            r_pkt_count <= '0;
        end else if (w_start) begin
            r_begin     <= pkt_begin;
            r_end       <= pkt_end;
            r_wr_ptr    <= pkt_begin;
            r_pkt_count <= '0;
        end else if (w_complete) begin
            r_wr_ptr <= (w_at_end && w_wrap) ? r_begin : w_ptr_inc;
            if (r_m_eop && (r_pkt_count != c_COUNT_MAX)) begin
                r_pkt_count <= r_pkt_count + 16'd1;
            end
        end
    end

    // Packet framing and buffer-full stop flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_in_pkt <= 1'b0;
            r_stop   <= 1'b0;
        end else if (w_start) begin
            r_in_pkt <= 1'b0;
            r_stop   <= 1'b0;
        end else begin
            if (w_final) begin
                r_stop <= 1'b1;
            end
            if (w_accept) begin
                if (snk_sop) begin
                    r_in_pkt <= !snk_eop;
                end else if (snk_eop) begin
                    r_in_pkt <= 1'b0;
                end
            end
        end
    end

    // FIFO pointers; leftovers are flushed on buffer full and at capture start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fifo_wptr <= '0;
            r_fifo_rptr <= '0;
        end else if (w_start || w_final) begin
            r_fifo_rptr <= r_fifo_wptr;
        end else begin
            if (w_push) begin
                r_fifo_wptr <= r_fifo_wptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_fifo_rptr <= r_fifo_rptr + c_PTR_ONE;
            end
        end
    end

    // FIFO storage: data word plus its eop marker.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_fifo_wptr[c_AW-1:0]] <= {snk_eop, snk_data};
        end
    end

    // Bus request register; request and data hold while the slave stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_m_write     <= 1'b0;
            r_m_eop       <= 1'b0;
            r_m_writedata <= '0;
        end else if (w_pop) begin
            r_m_write                <= 1'b1;
            {r_m_eop, r_m_writedata} <= r_mem[r_fifo_rptr[c_AW-1:0]];
        end else if (w_complete) begin
            r_m_write <= 1'b0;
        end
    end

    assign state       = r_state;
    assign snk_ready   = w_snk_ready;
    assign m_address   = r_wr_ptr;
    assign m_write     = r_m_write;
    assign m_writedata = r_m_writedata;
    assign wr_ptr      = r_wr_ptr;
    assign pkt_count   = r_pkt_count;

endmodule
`default_nettype wire

// File: tb/tb_pkt_capture_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pkt_capture_writer
// Description : Directed self-checking bench for pkt_capture_writer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pkt_capture_writer;

    logic        clk;
    logic        reset;
    logic [31:0] control;
    logic [31:0] pkt_begin;
    logic [31:0] pkt_end;
    logic [1:0]  state;
    logic [31:0] snk_data;
    logic        snk_valid;
    logic        snk_sop;
    logic        snk_eop;
    logic        snk_ready;
    logic [31:0] m_address;
    logic        m_write;
    logic [31:0] m_writedata;
    logic        m_waitrequest;
    logic [31:0] wr_ptr;
    logic [15:0] pkt_count;

    int          tests;
    int          fails;
    int          acc;
    logic [31:0] held_addr;
    logic [31:0] held_data;
    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];

    pkt_capture_writer #(.N(32), .FIFO_DEPTH(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .control       (control),
        .pkt_begin     (pkt_begin),
        .pkt_end       (pkt_end),
        .state         (state),
        .snk_data      (snk_data),
        .snk_valid     (snk_valid),
        .snk_sop       (snk_sop),
        .snk_eop       (snk_eop),
        .snk_ready     (snk_ready),
        .m_address     (m_address),
        .m_write       (m_write),
        .m_writedata   (m_writedata),
        .m_waitrequest (m_waitrequest),
        .wr_ptr        (wr_ptr),
        .pkt_count     (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log every completed bus write.
    always @(posedge clk) begin
        if (reset && m_write && !m_waitrequest) begin
            wq_addr.push_back(m_address);
            wq_data.push_back(m_writedata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_wr(input string tag, input int idx, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] oa;
        logic [31:0] od;
        oa = (idx < wq_addr.size()) ? wq_addr[idx] : 32'hDEAD_DEAD;
        od = (idx < wq_data.size()) ? wq_data[idx] : 32'hDEAD_DEAD;
        check({tag, "_addr"}, oa, a);
        check({tag, "_data"}, od, d);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_state(input logic [1:0] s, input string tag);
        int n;
        n = 0;
        while (state !== s && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, {30'b0, state}, {30'b0, s});
    endtask

    task automatic wait_mwrite(input string tag);
        int n;
        n = 0;
        while (m_write !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'b0, m_write}, 32'd1);
    endtask

    // Offer one word at a negedge and hold it until the sink takes it.
    task automatic send(input logic [31:0] d, input logic s, input logic e, input string tag);
        int n;
        n = 0;
        snk_data  = d;
        snk_sop   = s;
        snk_eop   = e;
        snk_valid = 1'b1;
        #1;
        while (!snk_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            check({tag, "_accept_timeout"}, 32'd0, 32'd1);
        end
        @(negedge clk);
        snk_valid = 1'b0;
        snk_sop   = 1'b0;
        snk_eop   = 1'b0;
    endtask

    task automatic start(input logic [31:0] ctl, input logic [31:0] b, input logic [31:0] e);
        pkt_begin = b;
        pkt_end   = e;
        control   = ctl;
        wq_addr.delete();
        wq_data.delete();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        control = '0;
        pkt_begin = '0;
        pkt_end = '0;
        snk_data = '0;
        snk_valid = 1'b0;
        snk_sop = 1'b0;
        snk_eop = 1'b0;
        m_waitrequest = 1'b0;
        cycles(3);

        // Reset values
        check("rst_state", {30'b0, state}, 32'd0);
        check("rst_ready", {31'b0, snk_ready}, 32'd0);
        check("rst_mwrite", {31'b0, m_write}, 32'd0);
        check("rst_maddr", m_address, 32'd0);
        check("rst_mdata", m_writedata, 32'd0);
        check("rst_wrptr", wr_ptr, 32'd0);
        check("rst_count", {16'b0, pkt_count}, 32'd0);
        reset = 1'b1;
        cycles(2);

        // Basic 3-word packet
        start(32'h4, 32'h1000, 32'h1010);
        wait_state(2'b01, "t1_capture");
        check("t1_wrptr_load", wr_ptr, 32'h1000);
        send(32'hA0A0_0001, 1'b1, 1'b0, "t1_a");
        send(32'hB0B0_0002, 1'b0, 1'b0, "t1_b");
        send(32'hC0C0_0003, 1'b0, 1'b1, "t1_c");
        cycles(6);
        check("t1_nwr", wq_addr.size(), 32'd3);
        check_wr("t1_w0", 0, 32'h1000, 32'hA0A0_0001);
        check_wr("t1_w1", 1, 32'h1004, 32'hB0B0_0002);
        check_wr("t1_w2", 2, 32'h1008, 32'hC0C0_0003);
        check("t1_count", {16'b0, pkt_count}, 32'd1);
        check("t1_wrptr", wr_ptr, 32'h100C);
        check("t1_state", {30'b0, state}, 32'd1);
        control = 32'h0;
        wait_state(2'b00, "t1_idle");

        // Buffer full without wrap: 6-word packet into a 4-word buffer
        start(32'h4, 32'h1000, 32'h1010);
        wait_state(2'b01, "t3_capture");
        m_waitrequest = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(32'h3300_0000 + 32'(i), (i == 0), (i == 5), "t3_word");
        end
        m_waitrequest = 1'b0;
        cycles(10);
        check("t3_nwr", wq_addr.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check_wr("t3_w", i, 32'h1000 + 32'(4 * i), 32'h3300_0000 + 32'(i));
        end
        check("t3_state", {30'b0, state}, 32'd2);
        check("t3_ready", {31'b0, snk_ready}, 32'd0);
        check("t3_count", {16'b0, pkt_count}, 32'd0);
        control = 32'h0;
        wait_state(2'b00, "t3_idle");

        // Wrap: 6-word packet into a 4-word buffer with wrap set
        start(32'hC, 32'h1000, 32'h1010);
        wait_state(2'b01, "t4_capture");
        for (int i = 0; i < 6; i++) begin
            send(32'h4400_0000 + 32'(i), (i == 0), (i == 5), "t4_word");
        end
        cycles(8);
        check("t4_nwr", wq_addr.size(), 32'd6);
        check_wr("t4_w4", 4, 32'h1000, 32'h4400_0004);
        check_wr("t4_w5", 5, 32'h1004, 32'h4400_0005);
        check("t4_count", {16'b0, pkt_count}, 32'd1);
        check("t4_state", {30'b0, state}, 32'd1);
        check("t4_wrptr", wr_ptr, 32'h1008);
        control = 32'h0;
        wait_state(2'b00, "t4_idle");

        // Backpressure on the second write, then fill the FIFO
        start(32'h4, 32'h3000, 32'h3100);
        wait_state(2'b01, "t2_capture");
        send(32'hB000_0000, 1'b1, 1'b0, "t2_w0");
        cycles(3);
        m_waitrequest = 1'b1;
        send(32'hB000_0001, 1'b0, 1'b0, "t2_w1");
        wait_mwrite("t2_stall_seen");
        held_addr = m_address;
        held_data = m_writedata;
        check("t2_stall_addr", held_addr, 32'h3004);
        check("t2_stall_data", held_data, 32'hB000_0001);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t2_hold_addr", m_address, held_addr);
            check("t2_hold_data", m_writedata, held_data);
            check("t2_hold_write", {31'b0, m_write}, 32'd1);
        end
        m_waitrequest = 1'b0;
        cycles(3);
        m_waitrequest = 1'b1;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            snk_data  = 32'hB000_0002 + 32'(acc);
            snk_sop   = 1'b0;
            snk_eop   = 1'b0;
            snk_valid = 1'b1;
            #1;
            if (!snk_ready) break;
            @(negedge clk);
            acc++;
        end
        snk_valid = 1'b0;
        // Eight words sit in the FIFO and one is stalled on the bus.
        check("t2_fill_count", acc, 32'd9);
        check("t2_full_ready", {31'b0, snk_ready}, 32'd0);
        @(negedge clk);
        m_waitrequest = 1'b0;
        send(32'hB000_0002 + 32'(acc), 1'b0, 1'b1, "t2_eop");
        cycles(15);
        check("t2_nwr", wq_addr.size(), 32'd12);
        for (int i = 0; i < 12; i++) begin
            check_wr("t2_w", i, 32'h3000 + 32'(4 * i), 32'hB000_0000 + 32'(i));
        end
        check("t2_count", {16'b0, pkt_count}, 32'd1);
        control = 32'h0;
        wait_state(2'b00, "t2_idle");

        // Bad configurations
        start(32'h4, 32'h2000, 32'h1000);
        cycles(3);
        check("t5_err_state", {30'b0, state}, 32'd3);
        check("t5_err_ready", {31'b0, snk_ready}, 32'd0);
        check("t5_err_nwr", wq_addr.size(), 32'd0);
        control = 32'h0;
        cycles(2);
        check("t5_err_idle", {30'b0, state}, 32'd0);
        start(32'h4, 32'h1002, 32'h2000);
        cycles(3);
        check("t5_misalign", {30'b0, state}, 32'd3);
        control = 32'h0;
        wait_state(2'b00, "t5_misalign_idle");

        // Pre-sop words discarded; enable dropped mid-packet
        start(32'h4, 32'h4000, 32'h4100);
        wait_state(2'b01, "t5_capture");
        send(32'hD000_0000, 1'b0, 1'b0, "t5_d0");
        send(32'hD000_0001, 1'b0, 1'b0, "t5_d1");
        send(32'h5A00_0000, 1'b1, 1'b0, "t5_p0");
        control = 32'h0;
        cycles(3);
        check("t5_hold_capture", {30'b0, state}, 32'd1);
        send(32'h5A00_0001, 1'b0, 1'b1, "t5_p1");
        wait_state(2'b00, "t5_late_idle");
        check("t5_nwr", wq_addr.size(), 32'd2);
        check_wr("t5_w0", 0, 32'h4000, 32'h5A00_0000);
        check_wr("t5_w1", 1, 32'h4004, 32'h5A00_0001);
        check("t5_count", {16'b0, pkt_count}, 32'd1);

        // Asynchronous reset while a write is stalled
        start(32'h4, 32'h5000, 32'h5100);
        wait_state(2'b01, "t6_capture");
        m_waitrequest = 1'b1;
        send(32'h6600_0000, 1'b1, 1'b0, "t6_w0");
        wait_mwrite("t6_mwrite_up");
        reset = 1'b0;
        #1;
        check("t6_mwrite", {31'b0, m_write}, 32'd0);
        check("t6_state", {30'b0, state}, 32'd0);
        check("t6_wrptr", wr_ptr, 32'd0);
        check("t6_nwr", wq_addr.size(), 32'd0);
        control = 32'h0;
        m_waitrequest = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        cycles(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
